// File: rtl/instruction_decode.sv
// Instruction decode (ID) stage of a 5-stage, 32-bit pipelined CPU.
// This module:
//   - decodes the IF/ID instruction,
//   - owns the 32x32 register file,
//   - resolves BEQ inside ID,
//   - detects load-use and branch-operand hazards,
//   - holds the ID/EX pipeline register.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write-back
// value into the read ports. Undefined by default: reads then return the
// previously stored value.
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] programCounterIn,
  input  logic [31:0] instruction,
  input  logic [4:0]  writeRegister,
  input  logic [31:0] writeData,
  input  logic        regWrite,
  output logic [1:0]  writeBackControl,
  output logic [1:0]  memAccessControl,
  output logic [3:0]  calculationControl,
  output logic [31:0] programCounterOut,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] immediateOperand,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        branch,
  output logic [31:0] branchProgramCounter
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned OP_W     = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_LW    = 6'd1;
  localparam logic [OP_W-1:0] OP_SW    = 6'd2;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd3;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd4;

  // Instruction fields
  logic [OP_W-1:0]   op_f;
  logic [REG_AW-1:0] rs_f;
  logic [REG_AW-1:0] rt_f;
  logic [REG_AW-1:0] rd_f;
  logic [DATA_W-1:0] imm_ext;

  assign op_f    = instruction[31:26];
  assign rs_f    = instruction[25:21];
  assign rt_f    = instruction[20:16];
  assign rd_f    = instruction[15:11];
  assign imm_ext = {{16{instruction[15]}}, instruction[15:0]};

  // Register file storage and read values
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // ID/EX pipeline register
  logic [1:0]        wb_q,   wb_d;
  logic [1:0]        mem_q,  mem_d;
  logic [3:0]        calc_q, calc_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;

  // Decoded controls before bubble insertion
  logic [1:0] dec_wb;
  logic [1:0] dec_mem;
  logic [3:0] dec_calc;

  // Hazard signals
  logic              uses_rt;
  logic [REG_AW-1:0] ex_dest;
  logic              load_use;
  logic              branch_haz;
  logic              stall;

  // Register file write port; R0 is never written and reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (regWrite && (writeRegister != '0)) begin
      regs_q[writeRegister] <= writeData;
    end
  end

  // Register file read ports, optionally forwarding the write-back value
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_f != '0) rs_val = regs_q[rs_f];
    if (rt_f != '0) rt_val = regs_q[rt_f];
`ifdef REGFILE_BYPASS_EN
    if (regWrite && (writeRegister != '0) && (writeRegister == rs_f)) rs_val = writeData;
    if (regWrite && (writeRegister != '0) && (writeRegister == rt_f)) rt_val = writeData;
`else
`endif
  end

  // Main control decode: {regWrite,memToReg}, {memRead,memWrite}, {aluSrc,regDst,aluOp}
  always_comb begin
    dec_wb   = 2'b00;
    dec_mem  = 2'b00;
    dec_calc = 4'b0000;
    case (op_f)
      OP_RTYPE: begin dec_wb = 2'b10; dec_mem = 2'b00; dec_calc = 4'b0110; end
      OP_LW:    begin dec_wb = 2'b11; dec_mem = 2'b10; dec_calc = 4'b1000; end
      OP_SW:    begin dec_wb = 2'b00; dec_mem = 2'b01; dec_calc = 4'b1000; end
      OP_BEQ:   begin dec_wb = 2'b00; dec_mem = 2'b00; dec_calc = 4'b0001; end
      OP_ADDI:  begin dec_wb = 2'b10; dec_mem = 2'b00; dec_calc = 4'b1000; end
      default:  begin dec_wb = 2'b00; dec_mem = 2'b00; dec_calc = 4'b0000; end
    endcase
  end

  // Hazard detection against the instruction currently in EX
  always_comb begin
    // Only these opcodes read rt as a source operand
    uses_rt    = (op_f == OP_RTYPE) || (op_f == OP_SW) || (op_f == OP_BEQ);
    ex_dest    = calc_q[2] ? rd_q : rt_q;
    load_use   = mem_q[1] && (rt_q != '0) &&
                 ((rt_q == rs_f) || ((rt_q == rt_f) && uses_rt));
    // BEQ compares in ID, so any pending ALU result it needs forces a stall
    branch_haz = (op_f == OP_BEQ) && wb_q[1] && (ex_dest != '0) &&
                 ((ex_dest == rs_f) || (ex_dest == rt_f));
    stall      = load_use || branch_haz;
  end

  // Next ID/EX controls: a stall inserts a bubble
  always_comb begin
    wb_d   = dec_wb;
    mem_d  = dec_mem;
    calc_d = dec_calc;
    if (stall) begin
      wb_d   = '0;
      mem_d  = '0;
      calc_d = '0;
    end
  end

  // Stall, branch resolution and branch target (combinational outputs)
  always_comb begin
    pcWrite              = !stall;
    ifIdWrite            = !stall;
    branch               = (op_f == OP_BEQ) && (rs_val == rt_val) && !stall;
    branchProgramCounter = programCounterIn + {imm_ext[29:0], 2'b00};
  end

  // ID/EX pipeline register loads every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q   <= '0;
      mem_q  <= '0;
      calc_q <= '0;
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      wb_q   <= wb_d;
      mem_q  <= mem_d;
      calc_q <= calc_d;
      pc_q   <= programCounterIn;
      rd1_q  <= rs_val;
      rd2_q  <= rt_val;
      imm_q  <= imm_ext;
      rs_q   <= rs_f;
      rt_q   <= rt_f;
      rd_q   <= rd_f;
    end
  end

  assign writeBackControl   = wb_q;
  assign memAccessControl   = mem_q;
  assign calculationControl = calc_q;
  assign programCounterOut  = pc_q;
  assign readData1          = rd1_q;
  assign readData2          = rd2_q;
  assign immediateOperand   = imm_q;
  assign rs                 = rs_q;
  assign rt                 = rt_q;
  assign rd                 = rd_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: a table of per-cycle vectors plus reset sequences.
// Expected ID/EX contents are queued when a vector is driven and checked after the edge.
`timescale 1ns/1ps
module tb_instruction_decode;

  logic        clk;
  logic        reset;
  logic [31:0] programCounterIn;
  logic [31:0] instruction;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic [1:0]  writeBackControl;
  logic [1:0]  memAccessControl;
  logic [3:0]  calculationControl;
  logic [31:0] programCounterOut;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] immediateOperand;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        branch;
  logic [31:0] branchProgramCounter;

  instruction_decode dut (
    .clk                 (clk),
    .reset               (reset),
    .programCounterIn    (programCounterIn),
    .instruction         (instruction),
    .writeRegister       (writeRegister),
    .writeData           (writeData),
    .regWrite            (regWrite),
    .writeBackControl    (writeBackControl),
    .memAccessControl    (memAccessControl),
    .calculationControl  (calculationControl),
    .programCounterOut   (programCounterOut),
    .readData1           (readData1),
    .readData2           (readData2),
    .immediateOperand    (immediateOperand),
    .rs                  (rs),
    .rt                  (rt),
    .rd                  (rd),
    .pcWrite             (pcWrite),
    .ifIdWrite           (ifIdWrite),
    .branch              (branch),
    .branchProgramCounter(branchProgramCounter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: inputs for a cycle and hand-derived expectations
  // (ctrl = {wb[1:0], mem[1:0], calc[3:0]} for the unstalled instruction)
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        we;
    logic [7:0]  ctrl;
    logic        stall;
    logic        br;
  } vec_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rf [32];
  vec_t        vecs [20];
  int          checks = 0;
  int          errors = 0;

  localparam logic [7:0] C_R    = 8'b10_00_0110;
  localparam logic [7:0] C_LW   = 8'b11_10_1000;
  localparam logic [7:0] C_SW   = 8'b00_01_1000;
  localparam logic [7:0] C_BEQ  = 8'b00_00_0001;
  localparam logic [7:0] C_ADDI = 8'b10_00_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'd0, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [4:0] wreg, input logic [31:0] wdata, input logic we,
                              input logic [7:0] ctrl, input logic stall, input logic br);
    vec_t v;
    v.instr = instr; v.pc = pc; v.wreg = wreg; v.wdata = wdata; v.we = we;
    v.ctrl = ctrl; v.stall = stall; v.br = br;
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] n, input logic [4:0] wreg,
                                             input logic [31:0] wdata, input logic we);
    if (n == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && (wreg == n)) return wdata;
`else
    if (we && (wreg == n) && (wdata === 32'hx)) return 32'd0;
`endif
    return model_rf[n];
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_wb"},   32'(writeBackControl),   32'd0);
    chk({tag, "_mem"},  32'(memAccessControl),   32'd0);
    chk({tag, "_calc"}, 32'(calculationControl), 32'd0);
    chk({tag, "_pc"},   programCounterOut,       32'd0);
    chk({tag, "_rd1"},  readData1,               32'd0);
    chk({tag, "_rd2"},  readData2,               32'd0);
    chk({tag, "_imm"},  immediateOperand,        32'd0);
    chk({tag, "_rs"},   32'(rs),                 32'd0);
    chk({tag, "_rt"},   32'(rt),                 32'd0);
    chk({tag, "_rd"},   32'(rd),                 32'd0);
  endtask

  // Pop the oldest expectation and compare against the ID/EX outputs
  task automatic check_out(input int idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("v%0d_wb", idx),   32'(writeBackControl),   32'(e.ctrl[7:6]));
      chk($sformatf("v%0d_mem", idx),  32'(memAccessControl),   32'(e.ctrl[5:4]));
      chk($sformatf("v%0d_calc", idx), 32'(calculationControl), 32'(e.ctrl[3:0]));
      chk($sformatf("v%0d_pc", idx),   programCounterOut,       e.pc);
      chk($sformatf("v%0d_rd1", idx),  readData1,               e.rd1);
      chk($sformatf("v%0d_rd2", idx),  readData2,               e.rd2);
      chk($sformatf("v%0d_imm", idx),  immediateOperand,        e.imm);
      chk($sformatf("v%0d_rs", idx),   32'(rs),                 32'(e.rs));
      chk($sformatf("v%0d_rt", idx),   32'(rt),                 32'(e.rt));
      chk($sformatf("v%0d_rd", idx),   32'(rd),                 32'(e.rd));
    end
  endtask

  // Drive one vector, check combinational outputs, queue and check registered ones
  task automatic step(input vec_t v, input int idx);
    exp_t        e;
    logic [31:0] ins;
    logic [31:0] sx;
    ins = v.instr;
    sx  = {{16{ins[15]}}, ins[15:0]};
    @(negedge clk);
    instruction      = v.instr;
    programCounterIn = v.pc;
    writeRegister    = v.wreg;
    writeData        = v.wdata;
    regWrite         = v.we;
    #1;
    chk($sformatf("v%0d_pcWrite", idx),   32'(pcWrite),   32'(!v.stall));
    chk($sformatf("v%0d_ifIdWrite", idx), 32'(ifIdWrite), 32'(!v.stall));
    chk($sformatf("v%0d_branch", idx),    32'(branch),    32'(v.br));
    chk($sformatf("v%0d_bpc", idx),       branchProgramCounter, v.pc + (sx << 2));
    e.ctrl = v.stall ? 8'd0 : v.ctrl;
    e.pc   = v.pc;
    e.rd1  = model_read(ins[25:21], v.wreg, v.wdata, v.we);
    e.rd2  = model_read(ins[20:16], v.wreg, v.wdata, v.we);
    e.imm  = sx;
    e.rs   = ins[25:21];
    e.rt   = ins[20:16];
    e.rd   = ins[15:11];
    sb_q.push_back(e);
    @(posedge clk);
    if (v.we && (v.wreg != 5'd0)) model_rf[v.wreg] = v.wdata;
    #1;
    check_out(idx);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    vecs[0]  = mk(rtype(0, 1, 2),             32'h4,        5'd1, 32'hFFFF_FFFF, 1'b1, C_R,    1'b0, 1'b0);
    vecs[1]  = mk(itype(6'd3, 0, 31, 16'd10), 32'h0,        5'd0, 32'd0,         1'b0, C_BEQ,  1'b0, 1'b1);
    vecs[2]  = mk(itype(6'd4, 0, 3, 16'hFFFC), 32'h100,     5'd0, 32'd5,         1'b1, C_ADDI, 1'b0, 1'b0);
    vecs[3]  = mk(rtype(4, 0, 7),             32'h104,      5'd4, 32'd7,         1'b1, C_R,    1'b0, 1'b0);
    vecs[4]  = mk(rtype(4, 4, 8),             32'h108,      5'd0, 32'd0,         1'b0, C_R,    1'b0, 1'b0);
    vecs[5]  = mk(itype(6'd3, 8, 0, 16'd1),   32'h10C,      5'd0, 32'd0,         1'b0, C_BEQ,  1'b1, 1'b0);
    vecs[6]  = mk(itype(6'd3, 4, 0, 16'd2),   32'h110,      5'd0, 32'd0,         1'b0, C_BEQ,  1'b0, 1'b0);
    vecs[7]  = mk(itype(6'd1, 1, 5, 16'd0),   32'h114,      5'd0, 32'd0,         1'b0, C_LW,   1'b0, 1'b0);
    vecs[8]  = mk(rtype(5, 5, 6),             32'h118,      5'd0, 32'd0,         1'b0, C_R,    1'b1, 1'b0);
    vecs[9]  = mk(rtype(5, 5, 6),             32'h118,      5'd0, 32'd0,         1'b0, C_R,    1'b0, 1'b0);
    vecs[10] = mk(itype(6'd2, 2, 1, 16'd4),   32'h11C,      5'd0, 32'd0,         1'b0, C_SW,   1'b0, 1'b0);
    vecs[11] = mk(itype(6'd1, 0, 9, 16'd0),   32'h120,      5'd0, 32'd0,         1'b0, C_LW,   1'b0, 1'b0);
    vecs[12] = mk(itype(6'd2, 0, 9, 16'd0),   32'h124,      5'd0, 32'd0,         1'b0, C_SW,   1'b1, 1'b0);
    vecs[13] = mk(itype(6'd1, 0, 11, 16'd0),  32'h128,      5'd0, 32'd0,         1'b0, C_LW,   1'b0, 1'b0);
    vecs[14] = mk(itype(6'd4, 0, 11, 16'd5),  32'h12C,      5'd0, 32'd0,         1'b0, C_ADDI, 1'b0, 1'b0);
    vecs[15] = mk(itype(6'd1, 0, 0, 16'd0),   32'h130,      5'd0, 32'd0,         1'b0, C_LW,   1'b0, 1'b0);
    vecs[16] = mk(rtype(0, 0, 13),            32'h134,      5'd0, 32'd0,         1'b0, C_R,    1'b0, 1'b0);
    vecs[17] = mk(32'hFC00_8001,              32'h138,      5'd0, 32'd0,         1'b0, 8'd0,   1'b0, 1'b0);
    vecs[18] = mk(itype(6'd3, 1, 1, 16'd8),   32'hFFFF_FFF0, 5'd0, 32'd0,        1'b0, C_BEQ,  1'b0, 1'b1);
    vecs[19] = mk(rtype(1, 4, 12),            32'h4,        5'd0, 32'd0,         1'b0, C_R,    1'b0, 1'b0);

    reset            = 1'b1;
    instruction      = 32'd0;
    programCounterIn = 32'd0;
    writeRegister    = 5'd0;
    writeData        = 32'd0;
    regWrite         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_pcWrite", 32'(pcWrite), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) step(vecs[i], i);

    // Asynchronous reset in the middle of a cycle clears outputs at once
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    // R1 and R4 were written before the reset and must now read zero
    step(vecs[19], 19);

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
